spi_flash_rd_arb: RTL and testbench

//  Read-only controller for the board SPI NOR flash (N25Q-class, 0x03 READ, SPI mode 0).
//  Two requesters (0 = instruction fetch, 1 = data load) share one flash chip-select.

---
 rtl/spi_flash_rd_arb.sv | 149 ++++++++++++++
 tb/tb_spi_flash_rd_arb.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_rd_arb.sv
// Two-requester round-robin read controller for an SPI NOR flash (0x03 READ, mode 0).
// Each grant runs one 64-bit frame: command byte, 24-bit address, then 32 data bits.
module spi_flash_rd_arb #(
  parameter int CLK_DIV = 2,
  parameter int CS_IDLE = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req0_valid_i,
  input  logic [23:0] req0_addr_i,
  output logic        req0_ready_o,
  output logic        rsp0_valid_o,
  output logic [31:0] rsp0_data_o,
  input  logic        req1_valid_i,
  input  logic [23:0] req1_addr_i,
  output logic        req1_ready_o,
  output logic        rsp1_valid_o,
  output logic [31:0] rsp1_data_o,
  output logic        spi_sck_o,
  output logic        spi_cs_n_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i,
  output logic        busy_o
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int GAP_W = $clog2(CS_IDLE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((CS_IDLE > 1) ? CS_IDLE - 2 : 0);
  localparam logic [7:0] CMD_READ = 8'h03;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, GAP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic [5:0]       r_bit;
  logic [GAP_W-1:0] r_gap;
  logic             r_sck;
  logic             r_cs_n;
  logic             r_last_grant;
  logic             r_owner;
  logic [31:0]      r_tx;
  logic [31:0]      r_rx;
  logic             r_rsp0_valid;
  logic             r_rsp1_valid;
  logic [31:0]      r_rsp0_data;
  logic [31:0]      r_rsp1_data;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_half_end;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    w_half_end  = (r_div == DIV_LAST);
    case (r_state)
      IDLE: begin
        // With both valid, requester 0 wins only if requester 1 had the last grant.
        if (req0_valid_i && (!req1_valid_i || r_last_grant)) w_grant0 = 1'b1;
        else if (req1_valid_i)                               w_grant1 = 1'b1;
        if (w_grant0 || w_grant1) w_state_nxt = SHIFT;
      end
      SHIFT: if (w_half_end && r_sck && (r_bit == 6'd63)) w_state_nxt = DONE;
      DONE:  w_state_nxt = (CS_IDLE > 1) ? GAP : IDLE;
      GAP:   if (r_gap == GAP_LAST) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_div        <= '0;
      r_bit        <= '0;
      r_gap        <= '0;
      r_sck        <= 1'b0;
      r_cs_n       <= 1'b1;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_tx         <= '0;
      r_rx         <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_data  <= '0;
      r_rsp1_data  <= '0;
    end else begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      case (r_state)
        IDLE: if (w_grant0 || w_grant1) begin
          r_tx         <= {CMD_READ, w_grant1 ? req1_addr_i : req0_addr_i};
          r_cs_n       <= 1'b0;
          r_sck        <= 1'b0;
          r_div        <= '0;
          r_bit        <= '0;
          r_owner      <= w_grant1;
          r_last_grant <= w_grant1;
        end
        SHIFT: begin
          if (!w_half_end) begin
            r_div <= r_div + DIV_W'(1);
          end else begin
            r_div <= '0;
            if (!r_sck) begin
              r_sck <= 1'b1;
              if (r_bit[5]) r_rx <= {r_rx[30:0], spi_miso_i};
            end else begin
              // Zeros shift in behind the command/address, so mosi is 0 in the data phase.
              r_sck <= 1'b0;
              r_tx  <= {r_tx[30:0], 1'b0};
              r_bit <= r_bit + 6'd1;
              if (r_bit == 6'd63) begin
                r_cs_n <= 1'b1;
                if (r_owner) begin
                  r_rsp1_valid <= 1'b1;
                  r_rsp1_data  <= {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};
                end else begin
                  r_rsp0_valid <= 1'b1;
                  r_rsp0_data  <= {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};
                end
              end
            end
          end
        end
        DONE:    r_gap <= '0;
        GAP:     r_gap <= r_gap + GAP_W'(1);
        default: r_gap <= '0;
      endcase
    end
  end

  assign req0_ready_o = w_grant0;
  assign req1_ready_o = w_grant1;
  assign rsp0_valid_o = r_rsp0_valid;
  assign rsp1_valid_o = r_rsp1_valid;
  assign rsp0_data_o  = r_rsp0_data;
  assign rsp1_data_o  = r_rsp1_data;
  assign spi_sck_o    = r_sck;
  assign spi_cs_n_o   = r_cs_n;
  assign spi_mosi_o   = r_tx[31];
  assign busy_o       = (r_state != IDLE);

endmodule

// File: tb/tb_spi_flash_rd_arb.sv
// Scoreboard bench: two controllers (D=2/CS=2 and D=1/CS=1), each with a behavioural
// SPI flash model, bus-rule monitors and a response checker fed by an expectation queue.
module tb_spi_flash_rd_arb;

  typedef struct packed {
    int          inst;
    int          req;
    logic [31:0] data;
    int          gcyc;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        v   [2][2];
  logic [23:0] a   [2][2];
  logic        rdy [2][2];
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q [$];
  logic [31:0] cmd_q [$];
  int          glog  [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic mem_bit(input logic [23:0] base, input int idx);
    logic [23:0] ad;
    logic [7:0]  b;
    ad = base + 24'(idx / 8);
    case (ad)
      24'h000100: b = 8'h11;
      24'h000101: b = 8'h22;
      24'h000102: b = 8'h33;
      24'h000103: b = 8'h44;
      default:    b = ad[7:0];
    endcase
    return b[7 - (idx % 8)];
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int D   = (g == 0) ? 2 : 1;
    localparam int CI  = (g == 0) ? 2 : 1;
    localparam int LAT = 1 + 128 * D;
    logic        rv [2];
    logic [31:0] rd [2];
    logic        sck, csn, mosi, busy;
    logic        f_miso = 1'b0;
    int          fcnt   = 0;
    logic [31:0] fcmd   = '0;
    logic [31:0] fexp;
    logic        p_sck  = 1'b0;
    logic        p_mosi = 1'b0;
    int          hicnt  = 0;
    exp_t        e;

    spi_flash_rd_arb #(.CLK_DIV(D), .CS_IDLE(CI)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .req0_valid_i(v[g][0]), .req0_addr_i(a[g][0]), .req0_ready_o(rdy[g][0]),
      .rsp0_valid_o(rv[0]), .rsp0_data_o(rd[0]),
      .req1_valid_i(v[g][1]), .req1_addr_i(a[g][1]), .req1_ready_o(rdy[g][1]),
      .rsp1_valid_o(rv[1]), .rsp1_data_o(rd[1]),
      .spi_sck_o(sck), .spi_cs_n_o(csn), .spi_mosi_o(mosi), .spi_miso_i(f_miso),
      .busy_o(busy)
    );

    // Flash model: capture command/address on rising sck, drive data after falling sck.
    always @(posedge csn) fcnt = 0;
    always @(posedge sck) if (!csn) begin
      if (fcnt < 32) fcmd = {fcmd[30:0], mosi};
      fcnt++;
      if (fcnt == 32) begin
        checks++;
        if (cmd_q.size() == 0) begin
          errors++;
          $display("FAIL cmd_unexpected inst%0d: got %h with nothing expected", g, fcmd);
        end else begin
          fexp = cmd_q.pop_front();
          if (fcmd !== fexp) begin
            errors++;
            $display("FAIL cmd_stream inst%0d: got %h expected %h", g, fcmd, fexp);
          end
        end
      end
    end
    always @(negedge sck) if (!csn && fcnt >= 32 && fcnt < 64)
      f_miso <= mem_bit(fcmd[23:0], fcnt - 32);

    always @(negedge clk) begin
      if (rst_n) begin
        for (int r = 0; r < 2; r++) if (rv[r]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected inst%0d rsp%0d: data %h with nothing expected", g, r, rd[r]);
          end else begin
            e = exp_q.pop_front();
            if (e.inst != g || e.req != r || rd[r] !== e.data || (cyc - e.gcyc) != LAT) begin
              errors++;
              $display("FAIL rsp inst%0d rsp%0d: got data %h lat %0d, expected inst%0d rsp%0d data %h lat %0d",
                       g, r, rd[r], cyc - e.gcyc, e.inst, e.req, e.data, LAT);
            end
          end
        end
      end
      checks++;
      if (csn && sck) begin
        errors++; $display("FAIL sck_cs inst%0d: sck=1 while cs_n=1, required sck=0", g);
      end
      checks++;
      if (p_sck && sck && (mosi !== p_mosi)) begin
        errors++; $display("FAIL mosi_stable inst%0d: mosi %b -> %b while sck=1", g, p_mosi, mosi);
      end
      checks++;
      if ((busy && (rdy[g][0] || rdy[g][1])) || (!busy && (!csn || sck))) begin
        errors++;
        $display("FAIL busy_idle inst%0d: busy=%b ready=%b%b cs_n=%b sck=%b", g, busy, rdy[g][1], rdy[g][0], csn, sck);
      end
      if (csn) hicnt++;
      else begin
        if (hicnt > 0) begin
          checks++;
          if (hicnt < CI) begin
            errors++; $display("FAIL cs_gap inst%0d: got %0d cycles, required >= %0d", g, hicnt, CI);
          end
        end
        hicnt = 0;
      end
      p_sck  = sck;
      p_mosi = mosi;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_req(input int i, input int r, input logic [23:0] addr,
                        input logic [31:0] d, output int gc);
    bit   got;
    exp_t e;
    got = 1'b0;
    gc  = -1;
    a[i][r] = addr;
    v[i][r] = 1'b1;
    for (int n = 0; n < 3000 && !got; n++) begin
      @(negedge clk);
      if (rdy[i][r]) begin
        got    = 1'b1;
        gc     = cyc;
        e.inst = i;
        e.req  = r;
        e.data = d;
        e.gcyc = cyc;
        exp_q.push_back(e);
        cmd_q.push_back({8'h03, addr});
        glog.push_back(r);
      end
    end
    @(posedge clk); #1;
    v[i][r] = 1'b0;
    if (!got) begin
      errors++;
      $display("FAIL grant_timeout inst%0d req%0d: ready=0, required 1", i, r);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 3000 && exp_q.size() != 0; n++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int t0, t1, t2, t3, gc;
    bit got;
    for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) begin
      v[i][j] = 1'b0;
      a[i][j] = '0;
    end
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("reset_cs_n0",   32'(gi[0].csn),   32'd1);
    chk("reset_sck0",    32'(gi[0].sck),   32'd0);
    chk("reset_mosi0",   32'(gi[0].mosi),  32'd0);
    chk("reset_busy0",   32'(gi[0].busy),  32'd0);
    chk("reset_ready0",  32'({rdy[0][1], rdy[0][0]}), 32'd0);
    chk("reset_rsp0",    32'({gi[0].rv[1], gi[0].rv[0]}), 32'd0);
    chk("reset_data0",   gi[0].rd[0] | gi[0].rd[1], 32'd0);
    chk("reset_cs_n1",   32'(gi[1].csn),   32'd1);
    chk("reset_busy1",   32'(gi[1].busy),  32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Single read on the D=2 controller.
    do_req(0, 0, 24'h000100, 32'h44332211, t0);
    drain();

    // Both requesters held from reset: round robin 0,1,0,1 at the repeat rate.
    pulse_reset();
    glog.delete();
    fork
      begin
        do_req(0, 0, 24'h000200, 32'h03020100, t0);
        do_req(0, 0, 24'h0000A1, 32'hA4A3A2A1, t2);
      end
      begin
        do_req(0, 1, 24'hFFFFFC, 32'hFFFEFDFC, t1);
        do_req(0, 1, 24'h000103, 32'h06050444, t3);
      end
    join
    chk("rr_order", 32'((glog.size() == 4) ? {glog[0][7:0], glog[1][7:0], glog[2][7:0], glog[3][7:0]} : 32'hFFFFFFFF),
        32'h00010001);
    chk("rr_gap01", 32'(t1 - t0), 32'd259);
    chk("rr_gap12", 32'(t2 - t1), 32'd259);
    chk("rr_gap23", 32'(t3 - t2), 32'd259);
    drain();

    // Requester 1 arrives mid-transaction and is granted in the first IDLE cycle.
    fork
      do_req(0, 0, 24'h000010, 32'h13121110, t0);
      begin
        repeat (40) @(posedge clk); #1;
        do_req(0, 1, 24'h0000F0, 32'hF3F2F1F0, t1);
      end
    join
    chk("busy_defer", 32'(t1 - t0), 32'd259);
    drain();

    // Reset in the address phase (bit 20) aborts the frame without a response.
    a[0][0] = 24'h000300;
    v[0][0] = 1'b1;
    got = 1'b0;
    gc  = 0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (rdy[0][0]) begin got = 1'b1; gc = cyc; end
    end
    chk("abort_grant", 32'(got), 32'd1);
    @(posedge clk); #1 v[0][0] = 1'b0;
    repeat (81) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_cs_n", 32'(gi[0].csn),  32'd1);
    chk("abort_sck",  32'(gi[0].sck),  32'd0);
    chk("abort_busy", 32'(gi[0].busy), 32'd0);
    chk("abort_mosi", 32'(gi[0].mosi), 32'd0);
    chk("abort_data", gi[0].rd[0],     32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (300) @(posedge clk); #1;
    do_req(0, 0, 24'h000010, 32'h13121110, t0);
    drain();

    // D=1, CS_IDLE=1 controller: back-to-back grants 130 cycles apart.
    do_req(1, 0, 24'h000100, 32'h44332211, t0);
    do_req(1, 0, 24'h000103, 32'h06050444, t1);
    chk("d1_spacing", 32'(t1 - t0), 32'd130);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
